// File: rtl/jtoutrun_lineint_pkg.sv
// Shared register map, CTRL bit positions and the legacy 64/128/192 reset defaults
// for the raster line-interrupt controller.
package jtoutrun_lineint_pkg;

  localparam int REG_LINE    = 0;
  localparam int REG_CTRL    = 1;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_LATCH  = 1;
  localparam int CTRL_REPEAT = 2;
  localparam int CTRL_STEP   = 8;

  // STATUS sits right after the last channel's LINE/CTRL pair
  function automatic int status_addr(input int ch);
    return 2 * ch;
  endfunction

  function automatic logic [15:0] default_line(input int idx, input int vw);
    return 16'(((idx + 1) * 64) % (1 << vw));
  endfunction

  function automatic logic default_en(input int idx);
    return idx < 3;
  endfunction

endpackage

// File: rtl/jtoutrun_lineint_ch.sv
// One compare channel: LINE/CTRL registers, working compare line with repeat
// stepping, and its pending bit (pulse or latched).
module jtoutrun_lineint_ch
  import jtoutrun_lineint_pkg::*;
#(
  parameter int             VW   = 9,
  parameter logic [VW-1:0]  VMAX = 9'd261,
  parameter int             IDX  = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          line_ev,
  input  logic          frame_ev,
  input  logic [VW-1:0] vdump,
  input  logic          we_line,
  input  logic          we_ctrl,
  input  logic          clr,
  input  logic [15:0]   wdata,
  input  logic [15:0]   wmask,
  output logic [VW-1:0] line,
  output logic [15:0]   ctrl,
  output logic          pend
);

  localparam logic [VW-1:0] DEF_LINE = VW'(default_line(IDX, VW));

  logic          en, latch, rep;
  logic [7:0]    step;
  logic [VW-1:0] cur;
  logic [VW-1:0] line_nx;
  logic [VW:0]   sum;
  logic          hit, en_nx, pend_nx;

  always_comb begin
    line_nx = (line & ~wmask[VW-1:0]) | (wdata[VW-1:0] & wmask[VW-1:0]);
    en_nx   = (we_ctrl && wmask[CTRL_EN]) ? wdata[CTRL_EN] : en;
    hit     = line_ev && en && (vdump == cur);
    sum     = {1'b0, cur} + (VW+1)'(step);
    // pulse clear, then W1C, then a fresh match wins; disabling overrides all
    pend_nx = pend;
    if (line_ev && !latch) pend_nx = 1'b0;
    if (clr)               pend_nx = 1'b0;
    if (hit)               pend_nx = 1'b1;
    if (!en_nx)            pend_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line  <= DEF_LINE;
      cur   <= DEF_LINE;
      en    <= default_en(IDX);
      latch <= 1'b0;
      rep   <= 1'b0;
      step  <= 8'd0;
      pend  <= 1'b0;
    end else begin
      pend <= pend_nx;
      en   <= en_nx;
      if (we_ctrl && wmask[0]) begin
        latch <= wdata[CTRL_LATCH];
        rep   <= wdata[CTRL_REPEAT];
      end
      if (we_ctrl && wmask[8]) step <= wdata[CTRL_STEP +: 8];
      // a LINE write beats the frame reload, which beats the repeat step
      if (we_line) begin
        line <= line_nx;
        cur  <= line_nx;
      end else if (frame_ev) begin
        cur <= line;
      end else if (hit && rep) begin
        cur <= (sum > {1'b0, VMAX}) ? line : sum[VW-1:0];
      end
    end
  end

  assign ctrl = {step, 5'd0, rep, latch, en};

  logic unused_wdat;
  assign unused_wdat = ^{wdata, wmask};

endmodule

// File: rtl/jtoutrun_lineint.sv
// Programmable raster line-interrupt controller: hs/LVBL edge detection, CPU register
// window, CH compare channels and the registered active-low interrupt request.
module jtoutrun_lineint
  import jtoutrun_lineint_pkg::*;
#(
  parameter int            CH   = 4,
  parameter int            VW   = 9,
  parameter logic [VW-1:0] VMAX = 9'd261,
  parameter int            AW   = $clog2(2*CH+1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pxl_cen,
  input  logic          hs,
  input  logic          LVBL,
  input  logic [VW-1:0] vdump,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   cpu_dout,
  input  logic [1:0]    dswn,
  output logic [15:0]   cpu_din,
  output logic          line_intn,
  output logic [CH-1:0] pend
);

  logic          hs_l, lvbl_l;
  logic          line_ev, frame_ev, wr, rd;
  logic [15:0]   wmask, rdata;
  logic [CH-1:0] we_line, we_ctrl, clr;
  logic [VW-1:0] line_q [CH];
  logic [15:0]   ctrl_q [CH];

  assign line_ev  = pxl_cen & hs & ~hs_l;
  assign frame_ev = pxl_cen & ~LVBL & lvbl_l;
  assign wr       = cs & ~&dswn;
  assign rd       = cs & &dswn;
  assign wmask    = {{8{~dswn[1]}}, {8{~dswn[0]}}};

  always_comb begin
    we_line = '0;
    we_ctrl = '0;
    clr     = '0;
    rdata   = '0;
    for (int i = 0; i < CH; i++) begin
      if (int'(addr) == 2*i + REG_LINE) begin
        we_line[i] = wr;
        rdata      = 16'(line_q[i]);
      end
      if (int'(addr) == 2*i + REG_CTRL) begin
        we_ctrl[i] = wr;
        rdata      = ctrl_q[i];
      end
    end
    if (int'(addr) == status_addr(CH)) begin
      clr   = cpu_dout[CH-1:0] & wmask[CH-1:0] & {CH{wr}};
      rdata = 16'(pend);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_l      <= 1'b0;
      lvbl_l    <= 1'b0;
      cpu_din   <= 16'd0;
      line_intn <= 1'b1;
    end else begin
      if (pxl_cen) begin
        hs_l   <= hs;
        lvbl_l <= LVBL;
      end
      if (rd) cpu_din <= rdata;
      line_intn <= ~|pend;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    jtoutrun_lineint_ch #(
      .VW   (VW),
      .VMAX (VMAX),
      .IDX  (g)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .line_ev  (line_ev),
      .frame_ev (frame_ev),
      .vdump    (vdump),
      .we_line  (we_line[g]),
      .we_ctrl  (we_ctrl[g]),
      .clr      (clr[g]),
      .wdata    (cpu_dout),
      .wmask    (wmask),
      .line     (line_q[g]),
      .ctrl     (ctrl_q[g]),
      .pend     (pend[g])
    );
  end

endmodule

// File: tb/tb_jtoutrun_lineint.sv
// Scoreboard bench for jtoutrun_lineint: directed scenarios plus randomized
// programming, checked against a line-by-line behavioural model.
module tb_jtoutrun_lineint;

  localparam int CH   = 4;
  localparam int VW   = 9;
  localparam int AW   = $clog2(2*CH+1);
  localparam int VMAX = 261;

  logic          clk = 1'b0, rstn = 1'b1, pxl_cen = 1'b0, hs = 1'b0, LVBL = 1'b1, cs = 1'b0;
  logic [VW-1:0] vdump = '0;
  logic [AW-1:0] addr = '0;
  logic [15:0]   cpu_dout = '0;
  logic [1:0]    dswn = 2'b11;
  wire  [15:0]   cpu_din;
  wire           line_intn;
  wire  [CH-1:0] pend;

  always #5 clk = ~clk;

  jtoutrun_lineint dut (
    .clk(clk), .rstn(rstn), .pxl_cen(pxl_cen), .hs(hs), .LVBL(LVBL), .vdump(vdump),
    .cs(cs), .addr(addr), .cpu_dout(cpu_dout), .dswn(dswn),
    .cpu_din(cpu_din), .line_intn(line_intn), .pend(pend)
  );

  int total = 0, bad = 0;

  // behavioural model: register contents and per-channel next line to match
  int m_line [CH], m_en [CH], m_latch [CH], m_rep [CH], m_step [CH], m_cur [CH];
  bit m_pend [CH];

  typedef struct packed { logic [CH-1:0] p; logic n; } exp_t;
  exp_t        exp_q [$];
  int          tag_q [$];
  logic [15:0] rd_q [$];
  int          rda_q [$];
  logic        chk = 1'b0, chk_seen = 1'b0, rd_seen = 1'b0;

  function automatic logic [CH-1:0] m_pvec();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin
      m_line[i] = ((i + 1) * 64) % 512;
      m_cur[i]  = m_line[i];
      m_en[i]   = (i < 3) ? 1 : 0;
      m_latch[i] = 0; m_rep[i] = 0; m_step[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic m_write(input int a, input logic [15:0] d, input logic [1:0] ds);
    logic [15:0] mk, nw, old;
    int i;
    mk = {{8{~ds[1]}}, {8{~ds[0]}}};
    i  = a / 2;
    if (a < 2*CH && a % 2 == 0) begin
      old = 16'(m_line[i]);
      nw  = (old & ~mk) | (d & mk);
      m_line[i] = int'(nw) % 512;
      m_cur[i]  = m_line[i];
    end else if (a < 2*CH) begin
      if (!ds[0]) begin m_en[i] = d[0]; m_latch[i] = d[1]; m_rep[i] = d[2]; end
      if (!ds[1]) m_step[i] = int'(d[15:8]);
      if (m_en[i] == 0) m_pend[i] = 0;
    end else if (a == 2*CH) begin
      for (int j = 0; j < CH; j++) if (d[j] && mk[j]) m_pend[j] = 0;
    end
  endtask

  function automatic logic [15:0] m_read(input int a);
    int i;
    i = a / 2;
    if (a < 2*CH && a % 2 == 0) return 16'(m_line[i]);
    if (a < 2*CH) return 16'((m_step[i] << 8) | (m_rep[i] << 2) | (m_latch[i] << 1) | m_en[i]);
    if (a == 2*CH) return 16'(m_pvec());
    return 16'h0000;
  endfunction

  task automatic push_chk(input int tag);
    exp_t e;
    e.p = m_pvec();
    e.n = ~|e.p;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    chk = 1'b1;
  endtask

  task automatic check_now(input int tag);
    push_chk(tag);
    @(posedge clk); #1;
    chk = 1'b0;
  endtask

  task automatic cpu_wr(input int a, input logic [15:0] d, input logic [1:0] ds = 2'b00);
    @(posedge clk); #1;
    cs = 1'b1; addr = AW'(a); cpu_dout = d; dswn = ds;
    m_write(a, d, ds);
    @(posedge clk); #1;
    cs = 1'b0; dswn = 2'b11;
  endtask

  task automatic cpu_rd(input int a);
    @(posedge clk); #1;
    cs = 1'b1; addr = AW'(a); dswn = 2'b11;
    rd_q.push_back(m_read(a));
    rda_q.push_back(a);
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic frame_start();
    @(posedge clk); #1;
    LVBL = 1'b1; pxl_cen = 1'b1; hs = 1'b0;
    @(posedge clk); #1;
    LVBL = 1'b0;
    for (int i = 0; i < CH; i++) m_cur[i] = m_line[i];
    @(posedge clk); #1;
    LVBL = 1'b1;
  endtask

  // one raster line; the hs rising edge is seen in exactly one cycle, optionally with a write
  task automatic line(input int v, input bit ew = 1'b0, input int a = 0,
                      input logic [15:0] d = 16'h0, input logic [1:0] ds = 2'b11);
    bit hit [CH];
    int s;
    @(posedge clk); #1;
    vdump = VW'(v); hs = 1'b0; pxl_cen = 1'b1;
    @(posedge clk); #1;
    hs = 1'b1; pxl_cen = 1'b1;
    if (ew) begin cs = 1'b1; addr = AW'(a); cpu_dout = d; dswn = ds; end
    for (int i = 0; i < CH; i++) begin
      hit[i] = (m_en[i] != 0) && (v == m_cur[i]);
      if (m_latch[i] == 0) m_pend[i] = 0;
    end
    if (ew && a == 2*CH) m_write(a, d, ds);
    for (int i = 0; i < CH; i++) if (hit[i]) begin
      m_pend[i] = 1;
      if (m_rep[i] != 0) begin
        s = m_cur[i] + m_step[i];
        m_cur[i] = (s > VMAX) ? m_line[i] : s;
      end
    end
    if (ew && a != 2*CH) m_write(a, d, ds);
    @(posedge clk); #1;
    cs = 1'b0; dswn = 2'b11; pxl_cen = 1'($urandom);
    push_chk(v);
    @(posedge clk); #1;
    chk = 1'b0; pxl_cen = 1'($urandom);
    repeat (2) begin @(posedge clk); #1; pxl_cen = 1'($urandom); end
  endtask

  task automatic lines(input int from, input int to);
    for (int v = from; v <= to; v++) line(v);
  endtask

  task automatic check_val(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  always @(posedge clk) begin
    rd_seen  <= cs && (dswn == 2'b11);
    chk_seen <= chk;
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] r;
    int          t;
    if (rd_seen) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_underflow got=%h", cpu_din);
      end else begin
        r = rd_q.pop_front();
        t = rda_q.pop_front();
        if (cpu_din !== r) begin
          bad++;
          $display("FAIL rd addr=%0d got=%h want=%h", t, cpu_din, r);
        end
      end
    end
    if (chk_seen) begin
      total += 2;
      if (exp_q.size() == 0) begin
        bad += 2;
        $display("FAIL irq_underflow got pend=%b intn=%b", pend, line_intn);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (pend !== e.p) begin
          bad++;
          $display("FAIL pend line=%0d got=%b want=%b", t, pend, e.p);
        end
        if (line_intn !== e.n) begin
          bad++;
          $display("FAIL intn line=%0d got=%b want=%b", t, line_intn, e.n);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int r;
    m_reset();
    #2 rstn = 1'b0;
    #2;
    check_val("rst_intn", int'(line_intn), 1);
    check_val("rst_din", int'(cpu_din), 0);
    check_val("rst_pend", int'(pend), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int a = 0; a < 12; a++) cpu_rd(a);

    // legacy 64/128/192 pulses
    frame_start();
    lines(0, VMAX);

    // latched channel 0 at line 20, released by W1C
    cpu_wr(0, 16'd20);
    cpu_wr(1, 16'h0003);
    frame_start();
    lines(0, 45);
    cpu_rd(2*CH);
    cpu_wr(2*CH, 16'h0001, 2'b10);
    check_now(-1);

    // repeat channel 1: 100,150,200,250 then wrap to 100
    cpu_wr(1, 16'h0000);
    cpu_wr(2, 16'd100);
    cpu_wr(3, {8'd50, 8'h05});
    cpu_wr(5, 16'h0000);
    cpu_rd(3);
    frame_start();
    lines(0, VMAX);
    frame_start();
    lines(0, VMAX);

    // W1C colliding with a match: set wins
    cpu_wr(0, 16'd64);
    cpu_wr(1, 16'h0001);
    frame_start();
    lines(0, 63);
    line(64, 1'b1, 2*CH, 16'h0001, 2'b10);
    lines(65, 66);

    // LINE rewrite during the matching event
    frame_start();
    lines(0, 63);
    line(64, 1'b1, 0, 16'd70, 2'b00);
    lines(65, 75);
    frame_start();
    lines(0, 75);

    // async reset mid-frame with channel 2 latched-pending
    cpu_wr(4, 16'd120);
    cpu_wr(5, 16'h0003);
    frame_start();
    lines(0, 130);
    cpu_rd(2*CH);
    @(posedge clk); #1;
    rstn = 1'b0;
    m_reset();
    #1;
    check_val("arst_intn", int'(line_intn), 1);
    check_val("arst_din", int'(cpu_din), 0);
    check_val("arst_pend", int'(pend), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cpu_rd(4);
    cpu_rd(5);
    lines(131, 200);

    // randomized programming and traffic
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < CH; c++) begin
        cpu_wr(2*c, 16'($urandom_range(0, VMAX)));
        cpu_wr(2*c+1, {8'($urandom_range(1, 120)), 5'd0, 3'($urandom)});
      end
      frame_start();
      for (int v = 0; v <= VMAX; v++) begin
        r = $urandom_range(0, 99);
        if (r < 4) line(v, 1'b1, $urandom_range(0, 2*CH), 16'($urandom), 2'($urandom_range(0, 2)));
        else line(v);
        r = $urandom_range(0, 99);
        if (r < 8)       cpu_rd($urandom_range(0, 15));
        else if (r < 12) cpu_wr(2*CH, 16'($urandom));
        else if (r < 14) cpu_wr($urandom_range(0, 15), 16'($urandom), 2'($urandom_range(0, 2)));
      end
    end

    repeat (5) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0 || rd_q.size() != 0) begin
      bad++;
      $display("FAIL leftover irq=%0d rd=%0d want 0", exp_q.size(), rd_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
